// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Memory-side responder for the core's data SRAM port. Loads have a fixed one-cycle
//   latency; stores honour byte enables. Addresses whose [31:16] equal CONF_HI hit a
//   small config-register block (LED, switches, compare timer); all others hit RAM,
//   which aliases on the unused upper address bits.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   data_sram_en      request valid
//   data_sram_wen     byte write enables (0 = read)
//   data_sram_addr    byte address, [1:0] ignored
//   data_sram_wdata   lane-aligned store data
//   data_sram_rdata   load data, valid the cycle after a read, held until the next read
//   switch_in         asynchronous board switches
//   led_out           LED register
//   timer_irq         timer interrupt level (pend & en)
module data_sram_responder #(
    parameter int unsigned ADDR_W  = 14,
    parameter logic [15:0] CONF_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic        timer_irq
);

    localparam logic [13:0] OffLed    = 14'(16'hF000 >> 2);
    localparam logic [13:0] OffSwitch = 14'(16'hF004 >> 2);
    localparam logic [13:0] OffCount  = 14'(16'hE000 >> 2);
    localparam logic [13:0] OffCmp    = 14'(16'hE004 >> 2);
    localparam logic [13:0] OffCtrl   = 14'(16'hE008 >> 2);

    // Byte-enable merge of new data over an old word.
    function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // Decode
    logic              w_sel_conf;
    logic              w_is_wr;
    logic              w_is_rd;
    logic [13:0]       w_off;
    logic [ADDR_W-1:0] w_idx;
    logic              w_unused_addr;

    assign w_sel_conf    = (data_sram_addr[31:16] == CONF_HI);
    assign w_is_wr       = data_sram_en && (data_sram_wen != 4'b0000);
    assign w_is_rd       = data_sram_en && (data_sram_wen == 4'b0000);
    assign w_off         = data_sram_addr[15:2];
    assign w_idx         = data_sram_addr[ADDR_W+1:2];
    assign w_unused_addr = ^data_sram_addr[1:0];

    // RAM: synchronous read, byte-lane write, no reset so it can map to block RAM.
    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_ram_dout;
    logic        w_ram_we;
    logic        w_ram_re;

    assign w_ram_we = w_is_wr && !w_sel_conf;
    assign w_ram_re = w_is_rd && !w_sel_conf;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
        if (w_ram_re) r_ram_dout <= r_mem[w_idx];
    end

    // Config registers
    logic [15:0] r_led;
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;
    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        r_en;
    logic        r_pend;

    logic        w_conf_we;
    logic        w_we_led;
    logic        w_we_count;
    logic        w_we_cmp;
    logic        w_we_ctrl;
    logic        w_pend_set;
    logic        w_pend_clr;
    logic [31:0] w_count_d;
    logic [31:0] w_led_word;
    logic [31:0] w_conf_rdata;

    assign w_conf_we  = w_is_wr && w_sel_conf;
    assign w_we_led   = w_conf_we && (w_off == OffLed);
    assign w_we_count = w_conf_we && (w_off == OffCount);
    assign w_we_cmp   = w_conf_we && (w_off == OffCmp);
    assign w_we_ctrl  = w_conf_we && (w_off == OffCtrl);

    // Compare uses the pre-increment count; a set in the same cycle as a clear wins.
    assign w_pend_set = r_en && (r_count == r_cmp);
    assign w_pend_clr = w_we_ctrl && data_sram_wen[0] && data_sram_wdata[1];
    assign w_led_word = merge_be({16'h0000, r_led}, data_sram_wdata, data_sram_wen);

    always_comb begin
        w_count_d = r_count;
        if (w_we_count) begin
            // A software write overrides the increment for this cycle.
            w_count_d = merge_be(r_count, data_sram_wdata, data_sram_wen);
        end else if (r_en) begin
            w_count_d = r_count + 32'd1;
        end
    end

    always_comb begin
        w_conf_rdata = 32'h0000_0000;
        case (w_off)
            OffLed:    w_conf_rdata = {16'h0000, r_led};
            OffSwitch: w_conf_rdata = {24'h000000, r_sw_sync};
            OffCount:  w_conf_rdata = r_count;
            OffCmp:    w_conf_rdata = r_cmp;
            OffCtrl:   w_conf_rdata = {30'h0, r_pend, r_en};
            default:   w_conf_rdata = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led     <= 16'h0000;
            r_sw_meta <= 8'h00;
            r_sw_sync <= 8'h00;
            r_count   <= 32'h0000_0000;
            r_cmp     <= 32'hFFFF_FFFF;
            r_en      <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            r_sw_meta <= switch_in;
            r_sw_sync <= r_sw_meta;
            r_count   <= w_count_d;
            r_pend    <= w_pend_set || (r_pend && !w_pend_clr);
            if (w_we_led) r_led <= w_led_word[15:0];
            if (w_we_cmp) r_cmp <= merge_be(r_cmp, data_sram_wdata, data_sram_wen);
            if (w_we_ctrl && data_sram_wen[0]) r_en <= data_sram_wdata[0];
        end
    end

    // Read response: r_rd_valid drops on reset so a read in flight is discarded and
    // rdata reads 0 until the next read. r_rd_conf selects which source was read last.
    logic        r_rd_valid;
    logic        r_rd_conf;
    logic [31:0] r_conf_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid  <= 1'b0;
            r_rd_conf   <= 1'b0;
            r_conf_dout <= 32'h0000_0000;
        end else if (w_is_rd) begin
            r_rd_valid <= 1'b1;
            r_rd_conf  <= w_sel_conf;
            if (w_sel_conf) r_conf_dout <= w_conf_rdata;
        end
    end

    always_comb begin
        data_sram_rdata = 32'h0000_0000;
        if (r_rd_valid) data_sram_rdata = r_rd_conf ? r_conf_dout : r_ram_dout;
    end

    assign led_out   = r_led;
    assign timer_irq = r_pend && r_en;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder. Read expectations go into a scoreboard
// queue when the read is driven and are popped when the response is due.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = 4'h0;
    logic [31:0] data_sram_addr = 32'h0;
    logic [31:0] data_sram_wdata = 32'h0;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch_in = 8'h00;
    logic [15:0] led_out;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_exp [$];
    string       q_tag [$];
    bit          rd_issued = 1'b0;

    data_sram_responder #(
        .ADDR_W  (14),
        .CONF_HI (16'hBFAF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch_in       (switch_in),
        .led_out         (led_out),
        .timer_irq       (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, retire any read driven in that cycle.
    task automatic tick();
        logic [31:0] e;
        string       t;
        @(posedge clk);
        #1;
        if (rd_issued) begin
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            chk(t, data_sram_rdata, e);
        end
        rd_issued       = 1'b0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        data_sram_en    = 1'b1;
        data_sram_wen   = be;
        data_sram_addr  = addr;
        data_sram_wdata = data;
        tick();
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'h0;
        data_sram_addr = addr;
        q_exp.push_back(exp);
        q_tag.push_back(tag);
        rd_issued = 1'b1;
        tick();
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_rdata", data_sram_rdata, 32'h0);
        chk("rst_led", {16'h0, led_out}, 32'h0);
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);
        rst = 1'b0;

        // Byte-lane write and alias
        wr(32'h0000_0100, 32'h1122_3344, 4'hF);
        wr(32'h0000_0100, 32'h00AA_0000, 4'b0100);
        rd(32'h0000_0100, 32'h11AA_3344, "lane_rd");
        rd(32'h1000_0100, 32'h11AA_3344, "alias_rd");

        // Latency and hold
        wr(32'h0000_0200, 32'h0000_0005, 4'hF);
        wr(32'h0000_0204, 32'h0000_0007, 4'hF);
        rd(32'h0000_0200, 32'h0000_0005, "rd_a");
        tick();
        chk("hold_idle1", data_sram_rdata, 32'h5);
        tick();
        chk("hold_idle2", data_sram_rdata, 32'h5);
        wr(32'h0000_0204, 32'h0000_0009, 4'hF);
        chk("hold_write", data_sram_rdata, 32'h5);
        rd(32'h0000_0200, 32'h0000_0005, "b2b_a");
        rd(32'h0000_0204, 32'h0000_0009, "b2b_b");

        // LED, switch, unmapped
        wr(32'hBFAF_F000, 32'h0000_BEEF, 4'hF);
        chk("led", {16'h0, led_out}, 32'h0000_BEEF);
        switch_in = 8'h5A;
        tick();
        tick();
        rd(32'hBFAF_F004, 32'h0000_005A, "switch");
        rd(32'hBFAF_1234, 32'h0000_0000, "unmapped");

        // Timer wrap and match
        wr(32'hBFAF_E000, 32'hFFFF_FFFE, 4'hF);
        wr(32'hBFAF_E004, 32'h0000_0001, 4'hF);
        wr(32'hBFAF_E008, 32'h0000_0001, 4'hF);
        chk("irq_at_en", {31'h0, timer_irq}, 32'h0);
        tick();
        rd(32'hBFAF_E000, 32'hFFFF_FFFF, "count_ff");
        rd(32'hBFAF_E000, 32'h0000_0000, "count_wrap");
        chk("irq_pre", {31'h0, timer_irq}, 32'h0);
        tick();
        chk("irq_set", {31'h0, timer_irq}, 32'h1);

        // Clear, then set-wins on a coincident match
        wr(32'hBFAF_E004, 32'h0000_0052, 4'hF);
        wr(32'hBFAF_E008, 32'h0000_0003, 4'hF);
        chk("irq_clr", {31'h0, timer_irq}, 32'h0);
        wr(32'hBFAF_E000, 32'h0000_0050, 4'hF);
        tick();
        tick();
        chk("irq_before_match", {31'h0, timer_irq}, 32'h0);
        wr(32'hBFAF_E008, 32'h0000_0003, 4'hF);
        chk("irq_set_wins", {31'h0, timer_irq}, 32'h1);

        // Write beats increment
        wr(32'hBFAF_E000, 32'h0000_0100, 4'hF);
        tick();
        rd(32'hBFAF_E000, 32'h0000_0101, "count_collide");

        // Async reset between a read request and its response
        chk("irq_before_rst", {31'h0, timer_irq}, 32'h1);
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'h0;
        data_sram_addr = 32'h0000_0200;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rdata", data_sram_rdata, 32'h0);
        chk("arst_led", {16'h0, led_out}, 32'h0);
        chk("arst_irq", {31'h0, timer_irq}, 32'h0);
        @(posedge clk);
        #1;
        data_sram_en = 1'b0;
        rst = 1'b0;
        chk("arst_hold", data_sram_rdata, 32'h0);
        tick();
        chk("arst_after", data_sram_rdata, 32'h0);
        rd(32'hBFAF_E004, 32'hFFFF_FFFF, "cmp_after_rst");
        rd(32'h0000_0100, 32'h11AA_3344, "ram_kept");

        chk("sb_empty", 32'(q_exp.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
